// File: rtl/lsq_pkg.sv
// lsq_pkg: shared definitions for the load-store queue.
//   XLEN / ROB_W_DEF / IO_BASE_DEF : default widths and the I/O window base
//   F3_*                           : RISC-V load/store funct3 codes
//   state_t                        : head-access FSM states
//   len_of()                       : access length in bytes from funct3
package lsq_pkg;

   localparam int          XLEN        = 32;
   localparam int          ROB_W_DEF   = 4;
   localparam logic [31:0] IO_BASE_DEF = 32'h0003_0000;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Only the low two funct3 bits encode the size; bit 2 is the unsigned flag.
   function automatic logic [2:0] len_of(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   len_of = 3'd1;
         2'b01:   len_of = 3'd2;
         default: len_of = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/lsq_load_ext.sv
// lsq_load_ext: selects the loaded bytes from the memory return word and
// sign- or zero-extends them to XLEN according to funct3.
//   func3 : funct3 of the load being completed
//   rdata : raw memory return data, loaded bytes in the low lanes
//   val   : value to broadcast as the load result
module lsq_load_ext
   import lsq_pkg::*;
(
   input  logic [2:0]      func3,
   input  logic [XLEN-1:0] rdata,
   output logic [XLEN-1:0] val
);

   always_comb begin
      val = rdata;
      case (func3)
         F3_B:    val = {{24{rdata[7]}}, rdata[7:0]};
         F3_H:    val = {{16{rdata[15]}}, rdata[15:0]};
         F3_BU:   val = {24'd0, rdata[7:0]};
         F3_HU:   val = {16'd0, rdata[15:0]};
         default: val = rdata;
      endcase
   end

endmodule

// File: rtl/lsq.sv
// lsq: parametrised load-store queue.
// Holds loads and stores in program order, snoops NCDB result channels to
// fill missing operands, and issues one memory access at a time from the
// head. Committed stores (a prefix from the head) survive a flush; loads to
// the I/O window wait until they are the oldest ROB entry.
//   clk, rst, rdy, flush        : clock, sync active-high reset, global enable, rollback
//   full                        : queue holds DEPTH entries
//   disp_*                      : one new entry per cycle from decode
//   cdb_valid/rob_pos/val       : NCDB broadcast channels, packed per channel
//   commit_store/commit_rob_pos : ROB commits a store
//   rob_head_valid/rob_head_pos : oldest ROB entry, gates I/O loads
//   mem_*                       : single-outstanding memory request interface
//   res_valid/rob_pos/val       : load result towards the CDB
module lsq
   import lsq_pkg::*;
#(
   parameter int          DEPTH   = 16,
   parameter int          NCDB    = 2,
   parameter int          ROB_W   = ROB_W_DEF,
   parameter logic [31:0] IO_BASE = IO_BASE_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic                  flush,
   output logic                  full,
   input  logic                  disp_valid,
   input  logic                  disp_is_store,
   input  logic [2:0]            disp_func3,
   input  logic                  disp_rs1_rdy,
   input  logic [ROB_W-1:0]      disp_rs1_tag,
   input  logic [31:0]           disp_rs1_val,
   input  logic                  disp_rs2_rdy,
   input  logic [ROB_W-1:0]      disp_rs2_tag,
   input  logic [31:0]           disp_rs2_val,
   input  logic [31:0]           disp_imm,
   input  logic [ROB_W-1:0]      disp_rob_pos,
   input  logic [NCDB-1:0]       cdb_valid,
   input  logic [NCDB*ROB_W-1:0] cdb_rob_pos,
   input  logic [NCDB*32-1:0]    cdb_val,
   input  logic                  commit_store,
   input  logic [ROB_W-1:0]      commit_rob_pos,
   input  logic                  rob_head_valid,
   input  logic [ROB_W-1:0]      rob_head_pos,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [31:0]           mem_addr,
   output logic [2:0]            mem_len,
   output logic [31:0]           mem_wdata,
   input  logic                  mem_done,
   input  logic [31:0]           mem_rdata,
   output logic                  res_valid,
   output logic [ROB_W-1:0]      res_rob_pos,
   output logic [31:0]           res_val
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Entry storage
   logic [DEPTH-1:0] valid_q, committed_q, store_q, rs1_rdy_q, rs2_rdy_q;
   logic [2:0]       func3_q   [DEPTH];
   logic [ROB_W-1:0] rs1_tag_q [DEPTH];
   logic [ROB_W-1:0] rs2_tag_q [DEPTH];
   logic [ROB_W-1:0] rob_q     [DEPTH];
   logic [31:0]      rs1_val_q [DEPTH];
   logic [31:0]      rs2_val_q [DEPTH];
   logic [31:0]      imm_q     [DEPTH];

   logic [PTR_W-1:0] head, tail, head_n, tail_n;
   logic [CNT_W-1:0] count, ccount, count_n, ccount_n;
   logic [DEPTH-1:0] valid_n, committed_n, commit_vec;

   state_t           state, state_n;

   logic             disp_acc, commit_hit;
   logic             d_rs1_rdy, d_rs2_rdy;
   logic [31:0]      d_rs1_val, d_rs2_val;

   logic             head_store, head_issuable;
   logic [31:0]      head_addr;
   logic             issue, pop, store_pop, load_res;

   logic [2:0]       cur_func3;
   logic [ROB_W-1:0] cur_rob;
   logic [31:0]      ext_val;

   lsq_load_ext u_ext (
      .func3 (cur_func3),
      .rdata (mem_rdata),
      .val   (ext_val)
   );

   assign full     = (count == CNT_W'(DEPTH));
   assign disp_acc = disp_valid && !full && !flush;

   // A not-ready operand can be satisfied by a broadcast in the dispatch cycle.
   always_comb begin
      d_rs1_rdy = disp_rs1_rdy;
      d_rs1_val = disp_rs1_val;
      d_rs2_rdy = disp_rs2_rdy;
      d_rs2_val = disp_rs2_val;
      for (int c = 0; c < NCDB; c++) begin
         if (cdb_valid[c] && !disp_rs1_rdy && cdb_rob_pos[c*ROB_W +: ROB_W] == disp_rs1_tag) begin
            d_rs1_rdy = 1'b1;
            d_rs1_val = cdb_val[c*32 +: 32];
         end
         if (cdb_valid[c] && !disp_rs2_rdy && cdb_rob_pos[c*ROB_W +: ROB_W] == disp_rs2_tag) begin
            d_rs2_rdy = 1'b1;
            d_rs2_val = cdb_val[c*32 +: 32];
         end
      end
   end

   always_comb begin
      commit_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         commit_vec[i] = commit_store && valid_q[i] && store_q[i] && !committed_q[i] &&
                         (rob_q[i] == commit_rob_pos);
      end
   end
   assign commit_hit = |commit_vec;

   // Head decode. Loads never issue in a flush cycle since they are about to
   // be squashed; I/O loads additionally wait to be non-speculative.
   always_comb begin
      head_store    = store_q[head];
      head_addr     = rs1_val_q[head] + imm_q[head];
      head_issuable = 1'b0;
      if (valid_q[head] && rs1_rdy_q[head]) begin
         if (head_store)
            head_issuable = rs2_rdy_q[head] && committed_q[head];
         else
            head_issuable = !flush &&
                            ((head_addr < IO_BASE) ||
                             (rob_head_valid && rob_head_pos == rob_q[head]));
      end
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else if (rdy)
         state <= state_n;
   end

   // FSM: next state. A flushed load in flight is dropped from the queue at
   // once but the memory handshake must still finish, hence DRAIN.
   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:
            if (head_issuable) state_n = ST_BUSY;
         ST_BUSY:
            if (mem_done)
               state_n = ST_IDLE;
            else if (flush && !mem_we)
               state_n = ST_DRAIN;
         ST_DRAIN:
            if (mem_done) state_n = ST_IDLE;
         default:
            state_n = ST_IDLE;
      endcase
   end

   // FSM: outputs and queue control strobes
   always_comb begin
      mem_req   = (state != ST_IDLE);
      issue     = (state == ST_IDLE) && head_issuable;
      pop       = (state == ST_BUSY) && (mem_done || (flush && !mem_we));
      store_pop = (state == ST_BUSY) && mem_done && mem_we;
      load_res  = (state == ST_BUSY) && mem_done && !mem_we && !flush;
   end

   // Pointer and occupancy update. On flush only the committed prefix
   // (including a commit landing this cycle) is kept.
   always_comb begin
      head_n   = head + PTR_W'(pop);
      ccount_n = ccount + CNT_W'(commit_hit) - CNT_W'(store_pop);
      if (flush) begin
         tail_n  = head_n + ccount_n[PTR_W-1:0];
         count_n = ccount_n;
      end else begin
         tail_n  = tail + PTR_W'(disp_acc);
         count_n = count + CNT_W'(disp_acc) - CNT_W'(pop);
      end
   end

   always_comb begin
      valid_n     = valid_q;
      committed_n = committed_q | commit_vec;
      if (pop) valid_n[head] = 1'b0;
      if (flush) valid_n = valid_n & committed_n;
      if (disp_acc) begin
         valid_n[tail]     = 1'b1;
         committed_n[tail] = 1'b0;
      end
   end

   // Control state, issue registers and result port
   always_ff @(posedge clk) begin
      if (rst) begin
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         ccount      <= '0;
         valid_q     <= '0;
         committed_q <= '0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_len     <= '0;
         mem_wdata   <= '0;
         cur_func3   <= '0;
         cur_rob     <= '0;
         res_valid   <= 1'b0;
         res_rob_pos <= '0;
         res_val     <= '0;
      end else if (!rdy) begin
         res_valid <= 1'b0;
      end else begin
         head        <= head_n;
         tail        <= tail_n;
         count       <= count_n;
         ccount      <= ccount_n;
         valid_q     <= valid_n;
         committed_q <= committed_n;
         res_valid   <= load_res;
         if (load_res) begin
            res_rob_pos <= cur_rob;
            res_val     <= ext_val;
         end
         if (issue) begin
            mem_we    <= head_store;
            mem_addr  <= head_addr;
            mem_len   <= len_of(func3_q[head]);
            mem_wdata <= rs2_val_q[head];
            cur_func3 <= func3_q[head];
            cur_rob   <= rob_q[head];
         end
      end
   end

   // Entry payload: wake-up from broadcasts, then the dispatch write
   always_ff @(posedge clk) begin
      if (rdy) begin
         for (int i = 0; i < DEPTH; i++) begin
            for (int c = 0; c < NCDB; c++) begin
               if (valid_q[i] && !rs1_rdy_q[i] && cdb_valid[c] &&
                   cdb_rob_pos[c*ROB_W +: ROB_W] == rs1_tag_q[i]) begin
                  rs1_rdy_q[i] <= 1'b1;
                  rs1_val_q[i] <= cdb_val[c*32 +: 32];
               end
               if (valid_q[i] && !rs2_rdy_q[i] && cdb_valid[c] &&
                   cdb_rob_pos[c*ROB_W +: ROB_W] == rs2_tag_q[i]) begin
                  rs2_rdy_q[i] <= 1'b1;
                  rs2_val_q[i] <= cdb_val[c*32 +: 32];
               end
            end
         end
         if (disp_acc) begin
            store_q[tail]   <= disp_is_store;
            func3_q[tail]   <= disp_func3;
            rs1_rdy_q[tail] <= d_rs1_rdy;
            rs1_tag_q[tail] <= disp_rs1_tag;
            rs1_val_q[tail] <= d_rs1_val;
            rs2_rdy_q[tail] <= d_rs2_rdy;
            rs2_tag_q[tail] <= disp_rs2_tag;
            rs2_val_q[tail] <= d_rs2_val;
            imm_q[tail]     <= disp_imm;
            rob_q[tail]     <= disp_rob_pos;
         end
      end
   end

endmodule

// File: tb/tb_lsq.sv
// tb_lsq: directed scoreboard bench for lsq. Stimulus pushes expected memory
// requests and load results into queues; monitor processes pop and compare
// whenever the DUT presents a request or a result. A small memory model
// answers each request after a short latency.
module tb_lsq;
   import lsq_pkg::*;

   localparam int DEPTH = 16;
   localparam int NCDB  = 2;
   localparam int ROB_W = 4;

   logic                  clk = 1'b0;
   logic                  rst, rdy, flush, full;
   logic                  disp_valid, disp_is_store;
   logic [2:0]            disp_func3;
   logic                  disp_rs1_rdy, disp_rs2_rdy;
   logic [ROB_W-1:0]      disp_rs1_tag, disp_rs2_tag, disp_rob_pos;
   logic [31:0]           disp_rs1_val, disp_rs2_val, disp_imm;
   logic [NCDB-1:0]       cdb_valid;
   logic [NCDB*ROB_W-1:0] cdb_rob_pos;
   logic [NCDB*32-1:0]    cdb_val;
   logic                  commit_store;
   logic [ROB_W-1:0]      commit_rob_pos;
   logic                  rob_head_valid;
   logic [ROB_W-1:0]      rob_head_pos;
   logic                  mem_req, mem_we, mem_done;
   logic [31:0]           mem_addr, mem_wdata, mem_rdata;
   logic [2:0]            mem_len;
   logic                  res_valid;
   logic [ROB_W-1:0]      res_rob_pos;
   logic [31:0]           res_val;

   always #5 clk = ~clk;

   lsq #(.DEPTH(DEPTH), .NCDB(NCDB), .ROB_W(ROB_W), .IO_BASE(32'h0003_0000)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .full(full),
      .disp_valid(disp_valid), .disp_is_store(disp_is_store), .disp_func3(disp_func3),
      .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_tag(disp_rs1_tag), .disp_rs1_val(disp_rs1_val),
      .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_tag(disp_rs2_tag), .disp_rs2_val(disp_rs2_val),
      .disp_imm(disp_imm), .disp_rob_pos(disp_rob_pos),
      .cdb_valid(cdb_valid), .cdb_rob_pos(cdb_rob_pos), .cdb_val(cdb_val),
      .commit_store(commit_store), .commit_rob_pos(commit_rob_pos),
      .rob_head_valid(rob_head_valid), .rob_head_pos(rob_head_pos),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
      .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
      .res_valid(res_valid), .res_rob_pos(res_rob_pos), .res_val(res_val)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [2:0]  len;
      logic [31:0] wdata;
   } req_t;

   typedef struct {
      logic [3:0]  rob;
      logic [31:0] val;
   } res_t;

   req_t        exp_req[$];
   res_t        exp_res[$];
   logic [31:0] rdq[$];

   int   checks   = 0;
   int   failures = 0;
   logic mem_hold = 1'b0;
   logic done_q   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
      end
   endtask

   task automatic expect_req(input logic we, input logic [31:0] addr, input logic [2:0] len,
                             input logic [31:0] wdata, input logic [31:0] rdata);
      req_t r;
      r.we = we; r.addr = addr; r.len = len; r.wdata = wdata;
      exp_req.push_back(r);
      rdq.push_back(rdata);
   endtask

   task automatic expect_res(input logic [3:0] rob, input logic [31:0] val);
      res_t s;
      s.rob = rob; s.val = val;
      exp_res.push_back(s);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic dispatch(input logic st, input logic [2:0] f3,
                           input logic r1r, input logic [3:0] r1t, input logic [31:0] r1v,
                           input logic r2r, input logic [3:0] r2t, input logic [31:0] r2v,
                           input logic [31:0] imm, input logic [3:0] rob);
      disp_valid = 1'b1; disp_is_store = st; disp_func3 = f3;
      disp_rs1_rdy = r1r; disp_rs1_tag = r1t; disp_rs1_val = r1v;
      disp_rs2_rdy = r2r; disp_rs2_tag = r2t; disp_rs2_val = r2v;
      disp_imm = imm; disp_rob_pos = rob;
      cycles(1);
      disp_valid = 1'b0;
   endtask

   task automatic load(input logic [2:0] f3, input logic [31:0] base, input logic [31:0] imm,
                       input logic [3:0] rob);
      dispatch(1'b0, f3, 1'b1, 4'd0, base, 1'b1, 4'd0, 32'd0, imm, rob);
   endtask

   task automatic store(input logic [2:0] f3, input logic [31:0] base, input logic [31:0] imm,
                        input logic [31:0] data, input logic [3:0] rob);
      dispatch(1'b1, f3, 1'b1, 4'd0, base, 1'b1, 4'd0, data, imm, rob);
   endtask

   task automatic commit(input logic [3:0] rob);
      commit_store = 1'b1; commit_rob_pos = rob;
      cycles(1);
      commit_store = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int max);
      int n = 0;
      while ((exp_req.size() != 0 || exp_res.size() != 0 || mem_req || res_valid) && n < max) begin
         cycles(1);
         n++;
      end
      chk(name, 32'(n < max), 32'd1);
   endtask

   // Memory model: answers each request two sampled cycles after it appears.
   initial begin : responder
      int lat = 0;
      mem_done = 1'b0; mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (mem_done) begin
            mem_done = 1'b0;
         end else if (mem_req && !mem_hold) begin
            lat++;
            if (lat >= 2) begin
               lat = 0;
               mem_done = 1'b1;
               mem_rdata = (rdq.size() != 0) ? rdq.pop_front() : 32'd0;
            end
         end
      end
   end

   always @(posedge clk) done_q <= mem_done;

   initial begin : monitor
      req_t r;
      res_t s;
      bit   seen = 1'b0;
      forever begin
         @(negedge clk);
         if (mem_req && !seen) begin
            seen = 1'b1;
            if (exp_req.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_req: got we=%0d addr=0x%08h, required no request", mem_we, mem_addr);
            end else begin
               r = exp_req.pop_front();
               chk("req_we", 32'(mem_we), 32'(r.we));
               chk("req_addr", mem_addr, r.addr);
               chk("req_len", 32'(mem_len), 32'(r.len));
               if (r.we) chk("req_wdata", mem_wdata, r.wdata);
            end
         end else if (!mem_req) begin
            seen = 1'b0;
         end
         if (res_valid) begin
            chk("res_after_done", 32'(done_q), 32'd1);
            if (exp_res.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_res: got rob=%0d val=0x%08h, required no result", res_rob_pos, res_val);
            end else begin
               s = exp_res.pop_front();
               chk("res_rob", 32'(res_rob_pos), 32'(s.rob));
               chk("res_val", res_val, s.val);
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      rst = 1'b1; rdy = 1'b1; flush = 1'b0;
      disp_valid = 1'b0; disp_is_store = 1'b0; disp_func3 = '0;
      disp_rs1_rdy = 1'b0; disp_rs1_tag = '0; disp_rs1_val = '0;
      disp_rs2_rdy = 1'b0; disp_rs2_tag = '0; disp_rs2_val = '0;
      disp_imm = '0; disp_rob_pos = '0;
      cdb_valid = '0; cdb_rob_pos = '0; cdb_val = '0;
      commit_store = 1'b0; commit_rob_pos = '0;
      rob_head_valid = 1'b0; rob_head_pos = '0;
      cycles(3);
      rst = 1'b0;

      // Reset state
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_len", 32'(mem_len), 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_rob", 32'(res_rob_pos), 32'd0);
      chk("rst_res_val", res_val, 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_count", 32'(dut.count), 32'd0);
      chk("rst_head", 32'(dut.head), 32'd0);

      // LW x5,4(x1) with x1=0x100
      expect_req(1'b0, 32'h104, 3'd4, 32'd0, 32'hDEAD_BEEF);
      expect_res(4'd1, 32'hDEAD_BEEF);
      load(F3_W, 32'h100, 32'd4, 4'd1);
      wait_drain("lw_drain", 50);

      // Byte/half loads with sign and zero extension
      expect_req(1'b0, 32'h201, 3'd1, 32'd0, 32'h1234_5680);
      expect_res(4'd2, 32'hFFFF_FF80);
      expect_req(1'b0, 32'h202, 3'd1, 32'd0, 32'hFFFF_FF80);
      expect_res(4'd3, 32'h0000_0080);
      expect_req(1'b0, 32'h1FE, 3'd2, 32'd0, 32'h0000_8001);
      expect_res(4'd4, 32'hFFFF_8001);
      expect_req(1'b0, 32'h210, 3'd2, 32'd0, 32'hABCD_8001);
      expect_res(4'd5, 32'h0000_8001);
      load(F3_B,  32'h200, 32'd1, 4'd2);
      load(F3_BU, 32'h200, 32'd2, 4'd3);
      load(F3_H,  32'h200, 32'hFFFF_FFFE, 4'd4);
      load(F3_HU, 32'h200, 32'h10, 4'd5);
      wait_drain("ext_drain", 100);

      // SW waiting for its data via CDB channel 1, then for commit
      dispatch(1'b1, F3_W, 1'b1, 4'd0, 32'h300, 1'b0, 4'd3, 32'd0, 32'd8, 4'd5);
      cycles(4);
      chk("sw_no_data_no_req", 32'(mem_req), 32'd0);
      cdb_valid = 2'b10; cdb_rob_pos = {4'd3, 4'd0}; cdb_val = {32'h55, 32'h0};
      cycles(1);
      cdb_valid = 2'b00;
      cycles(4);
      chk("sw_no_commit_no_req", 32'(mem_req), 32'd0);
      expect_req(1'b1, 32'h308, 3'd4, 32'h55, 32'd0);
      commit(4'd5);
      wait_drain("sw_drain", 50);

      // SH whose data arrives on channel 0 in the dispatch cycle
      expect_req(1'b1, 32'h312, 3'd2, 32'h1234, 32'd0);
      cdb_valid = 2'b01; cdb_rob_pos = {4'd0, 4'd7}; cdb_val = {32'h0, 32'h1234};
      dispatch(1'b1, F3_H, 1'b1, 4'd0, 32'h310, 1'b0, 4'd7, 32'd0, 32'd2, 4'd6);
      cdb_valid = 2'b00;
      commit(4'd6);
      wait_drain("sh_drain", 50);

      // I/O load held until it is the ROB head
      rob_head_valid = 1'b1; rob_head_pos = 4'd4;
      load(F3_W, 32'h0003_0000, 32'd0, 4'd6);
      cycles(5);
      chk("io_held", 32'(mem_req), 32'd0);
      expect_req(1'b0, 32'h0003_0000, 3'd4, 32'd0, 32'h1234_5678);
      expect_res(4'd6, 32'h1234_5678);
      rob_head_pos = 4'd6;
      wait_drain("io_drain", 50);
      rob_head_valid = 1'b0;

      // Two committed stores survive a flush; three loads are discarded
      store(F3_W, 32'h400, 32'd0, 32'hA1, 4'd8);
      store(F3_W, 32'h400, 32'd4, 32'hB2, 4'd9);
      load(F3_W, 32'h500, 32'd0, 4'd10);
      load(F3_W, 32'h500, 32'd4, 4'd11);
      load(F3_W, 32'h500, 32'd8, 4'd12);
      mem_hold = 1'b1;
      expect_req(1'b1, 32'h400, 3'd4, 32'hA1, 32'd0);
      expect_req(1'b1, 32'h404, 3'd4, 32'hB2, 32'd0);
      commit_store = 1'b1; commit_rob_pos = 4'd8;
      cycles(1);
      commit_rob_pos = 4'd9;
      cycles(1);
      commit_store = 1'b0; flush = 1'b1;
      cycles(1);
      flush = 1'b0;
      chk("flush_count", 32'(dut.count), 32'd2);
      chk("flush_ccount", 32'(dut.ccount), 32'd2);
      mem_hold = 1'b0;
      wait_drain("flush_st_drain", 50);
      cycles(6);
      chk("flush_st_empty", 32'(dut.count), 32'd0);

      // Flush of an outstanding load: DRAIN, no result, dispatch still accepted
      mem_hold = 1'b1;
      expect_req(1'b0, 32'h500, 3'd4, 32'd0, 32'hAAAA_5555);
      load(F3_W, 32'h500, 32'd0, 4'd13);
      cycles(2);
      flush = 1'b1;
      cycles(1);
      flush = 1'b0;
      chk("drain_state", 32'(dut.state), 32'(ST_DRAIN));
      chk("drain_count", 32'(dut.count), 32'd0);
      expect_req(1'b0, 32'h600, 3'd4, 32'd0, 32'h77);
      expect_res(4'd14, 32'h77);
      load(F3_W, 32'h600, 32'd0, 4'd14);
      chk("drain_disp_count", 32'(dut.count), 32'd1);
      mem_hold = 1'b0;
      wait_drain("drain_drain", 50);

      // rdy low freezes the queue
      rdy = 1'b0;
      load(F3_W, 32'h700, 32'd0, 4'd1);
      chk("rdy_frozen_count", 32'(dut.count), 32'd0);
      rdy = 1'b1;

      // Fill to DEPTH, drop an extra dispatch, then drain with wrap
      rst = 1'b1;
      cycles(2);
      rst = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         store(F3_W, 32'h1000, 32'(4 * i), 32'h100 + 32'(i), 4'(i));
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_count", 32'(dut.count), 32'd16);
      store(F3_W, 32'h2000, 32'd0, 32'hBAD, 4'd0);
      chk("extra_dropped_count", 32'(dut.count), 32'd16);
      for (int i = 0; i < DEPTH; i++)
         expect_req(1'b1, 32'h1000 + 32'(4 * i), 3'd4, 32'h100 + 32'(i), 32'd0);
      for (int i = 0; i < DEPTH; i++) begin
         commit_store = 1'b1; commit_rob_pos = 4'(i);
         cycles(1);
      end
      commit_store = 1'b0;
      wait_drain("fill_drain", 300);
      chk("wrap_head", 32'(dut.head), 32'd0);
      chk("wrap_count", 32'(dut.count), 32'd0);
      chk("wrap_full", 32'(full), 32'd0);

      cycles(3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lsq.md
# lsq

Parametrised load-store queue replacing the fixed 8-entry load/store buffer between decode, ROB, CDB and the memory controller. Holds loads and stores in program order, captures operands from NCDB broadcast channels, issues one memory access at a time from the head, and keeps committed stores across a flush. Also holds back loads to the I/O range until they are non-speculative.

## Interface
- DEPTH, 16, entries; power of two, ≥2
- NCDB, 2, result broadcast channels snooped
- ROB_W, 4, ROB position width
- IO_BASE, 32'h0003_0000, loads with addr ≥ IO_BASE are I/O
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- rdy  in  1  global enable; low freezes all state
- flush  in  1  misprediction rollback
- full  out  1  count==DEPTH
- disp_valid  in  1  dispatch one entry
- disp_is_store, disp_func3  in  1, 3  type; RISC-V funct3
- disp_rs1_rdy, disp_rs1_tag, disp_rs1_val  in  1, ROB_W, 32  base operand
- disp_rs2_rdy, disp_rs2_tag, disp_rs2_val  in  1, ROB_W, 32  store data
- disp_imm  in  32  offset
- disp_rob_pos  in  ROB_W  ROB slot
- cdb_valid  in  NCDB  per-channel broadcast
- cdb_rob_pos  in  NCDB*ROB_W  channel i at [i*ROB_W +: ROB_W]
- cdb_val  in  NCDB*32  channel i at [i*32 +: 32]
- commit_store, commit_rob_pos  in  1, ROB_W  ROB commits a store
- rob_head_valid, rob_head_pos  in  1, ROB_W  oldest ROB entry
- mem_req, mem_we  out  1, 1  request; 1=store
- mem_addr, mem_len, mem_wdata  out  32, 3, 32  address; bytes 1/2/4; store data
- mem_done, mem_rdata  in  1, 32  completion; load data in low bytes
- res_valid, res_rob_pos, res_val  out  1, ROB_W, 32  load result to CDB

## Operation
- Circular buffer: head, tail (log2 DEPTH bits, wrap), count (0..DEPTH), ccount = committed stores, always a prefix from head.
- Dispatch with full high is dropped. Entry: valid, fields, committed=0. Same-cycle CDB match on a not-ready operand tag captures cdb_val at dispatch.
- Wake-up: every valid not-ready operand compares tag against all NCDB channels; match captures value, sets ready. Channels carry distinct tags.
- Commit: commit_store marks the valid uncommitted store with matching rob_pos committed, ccount+1.
- Head issuable: valid, rs1 ready, and either store: rs2 ready and committed; or load: !flush and (addr < IO_BASE or (rob_head_valid and rob_head_pos==rob_pos)).
- addr = rs1+imm mod 2^32. mem_len from func3[1:0]: 00→1, 01→2, else 4.
- Load data: LB/LH sign-extend, LBU/LHU zero-extend, other funct3 → full word.
- FSM IDLE / BUSY / DRAIN:
- IDLE: head issuable → drive mem_* next edge, go BUSY.
- BUSY: hold mem_* until mem_done; on mem_done → IDLE, head+1, count−1, ccount−1 if store, load → res_valid pulse.
- flush: uncommitted entries invalidated; tail=head+ccount', count=ccount' (after same-cycle commit and completion). Commit in flush cycle survives. Outstanding uncommitted load in BUSY → DRAIN, entry dropped, head advanced.
- DRAIN: mem_req held until mem_done, no result, → IDLE. Dispatch accepted in DRAIN.
- Outstanding committed store continues through flush.

## Timing
- Reset: mem_req=0, mem_we=0, mem_addr=0, mem_len=0, mem_wdata=0, res_valid=0, res_rob_pos=0, res_val=0, full=0; head=tail=count=ccount=0; state IDLE; all entries invalid.
- rst beats flush and rdy; reset mid-access drops it.
- Issuable in cycle t → mem_req high t+1. mem_done at t+k → res_valid high t+k+1 for one cycle; mem_req low t+k+1; next issue decision t+k+1, request t+k+2.
- Dispatch and completion in one cycle at count==DEPTH: dispatch dropped, full seen by producer.
- rdy low: state frozen, res_valid 0.

## Structure
- Shared define header: funct3 codes, XLEN=32, ROB_W, IO_BASE default.
- Sub-module lsq_load_ext: combinational funct3-based byte select and sign/zero extension.
- Top holds entry arrays, pointers, CAM wake-up/commit loops, FSM.

## Test plan
- LW x5,4(x1), x1 ready =0x100 → mem_addr=0x104, len=4; rdata 0xDEADBEEF → res_val=0xDEADBEEF one cycle after mem_done.
- LB rdata 0x80, LBU rdata 0x80 → res_val 0xFFFFFF80, 0x00000080.
- SW rs2 tag 3 unready; cdb channel 1 broadcasts pos 3 val 0x55; commit_store pos → mem_we=1, wdata=0x55; no issue before commit.
- Load addr 0x30000 rob_pos 6, rob_head_pos 4 → no request; rob_head_pos 6 → request.
- Two committed SW + three uncommitted loads, flush → count=2, both stores written, no load issued.
- Fill DEPTH entries → full=1, extra dispatch ignored; drain all → head wraps to 0, count=0.
